// File: rtl/wm8978_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : wm8978_cfg_ctrl
//  Purpose  : Power-up configuration sequencer for the WM8978 codec. It waits
//             for the codec to power up, then writes a fixed 10-entry register
//             table through an I2C master using an exec/done handshake. It
//             also supports runtime headphone volume updates and full
//             re-configuration.
//  Ports    : clk, rst_n        - 50 MHz clock, asynchronous active-low reset
//             cfg_start         - pulse: rerun full table (DONE/ERR only)
//             vol_req, vol_in   - pulse + value: rewrite R52/R53 (DONE only)
//             i2c_exec/i2c_data - start pulse and {addr[6:0], val[8:0]}
//             i2c_done/ack_err  - transfer finished / NACK flag
//             busy, cfg_done, cfg_err - sequencer status
//  Revision : 1.0 - initial release
// ============================================================================
module wm8978_cfg_ctrl #(
  parameter logic [5:0]  WL        = 6'd16,
  parameter logic [19:0] PWR_DLY   = 20'd500000,
  parameter logic [15:0] GAP_DLY   = 16'd5000,
  parameter logic [2:0]  MAX_RETRY = 3'd3,
  parameter logic [5:0]  VOL_INIT  = 6'd40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic        vol_req,
  input  logic [5:0]  vol_in,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        i2c_exec,
  output logic [15:0] i2c_data,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam logic [3:0] LAST_IDX = 4'd9;
  localparam logic [3:0] VOL_IDX  = 4'd8;

  typedef enum logic [2:0] {
    S_PWR  = 3'd0,
    S_SEND = 3'd1,
    S_WACK = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [2:0]  retry, retry_nxt;
  logic [5:0]  vol, vol_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [1:0]  wlc;

  // R4 word-length field; unsupported lengths fall back to 16 bit.
  always_comb begin
    wlc = 2'b00;
    case (WL)
      6'd20:   wlc = 2'b01;
      6'd24:   wlc = 2'b10;
      6'd32:   wlc = 2'b11;
      default: wlc = 2'b00;
    endcase
  end

  // Register table: {addr[6:0], value[8:0]}. R52/R53 set the volume-update
  // bit (bit 8) with zero-cross and mute cleared.
  function automatic logic [15:0] table_word(input logic [3:0] i,
                                             input logic [5:0] v,
                                             input logic [1:0] w);
    case (i)
      4'd0:    return {7'd0,  9'h000};
      4'd1:    return {7'd1,  9'h01B};
      4'd2:    return {7'd2,  9'h1B3};
      4'd3:    return {7'd3,  9'h06F};
      4'd4:    return {7'd4,  2'b00, w, 5'b10000};
      4'd5:    return {7'd6,  9'h000};
      4'd6:    return {7'd14, 9'h108};
      4'd7:    return {7'd44, 9'h033};
      4'd8:    return {7'd52, 1'b1, 2'b00, v};
      4'd9:    return {7'd53, 1'b1, 2'b00, v};
      default: return 16'h0000;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    retry_nxt = retry;
    vol_nxt   = vol;
    cnt_nxt   = cnt;
    case (state)
      S_PWR: begin
        if (cnt + 20'd1 >= PWR_DLY) begin
          state_nxt = S_SEND;
          cnt_nxt   = 20'd0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      S_SEND: state_nxt = S_WACK;
      S_WACK: begin
        if (i2c_done) begin
          if (!i2c_ack_err) begin
            retry_nxt = 3'd0;
            if (idx == LAST_IDX) begin
              state_nxt = S_DONE;
            end else begin
              idx_nxt   = idx + 4'd1;
              state_nxt = S_GAP;
            end
          end else if (retry < MAX_RETRY) begin
            retry_nxt = retry + 3'd1;
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
      S_GAP: begin
        if (cnt + 20'd1 >= {4'd0, GAP_DLY}) begin
          state_nxt = S_SEND;
          cnt_nxt   = 20'd0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      S_DONE: begin
        // cfg_start has priority; a simultaneous vol_req is dropped.
        if (cfg_start) begin
          idx_nxt   = 4'd0;
          retry_nxt = 3'd0;
          cnt_nxt   = 20'd0;
          state_nxt = S_PWR;
        end else if (vol_req) begin
          vol_nxt   = vol_in;
          idx_nxt   = VOL_IDX;
          state_nxt = S_SEND;
        end
      end
      S_ERR: begin
        if (cfg_start) begin
          idx_nxt   = 4'd0;
          retry_nxt = 3'd0;
          cnt_nxt   = 20'd0;
          state_nxt = S_PWR;
        end
      end
      default: state_nxt = S_PWR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_PWR;
      idx      <= 4'd0;
      retry    <= 3'd0;
      vol      <= VOL_INIT;
      cnt      <= 20'd0;
      i2c_data <= 16'h0000;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      retry <= retry_nxt;
      vol   <= vol_nxt;
      cnt   <= cnt_nxt;
      // Data is loaded only on entry to SEND, using the index/volume that
      // SEND will present, so it stays stable through the whole transfer.
      if (state_nxt == S_SEND) begin
        i2c_data <= table_word(idx_nxt, vol_nxt, wlc);
      end
    end
  end

  assign i2c_exec = (state == S_SEND);
  assign cfg_done = (state == S_DONE);
  assign cfg_err  = (state == S_ERR);
  assign busy     = (state != S_DONE) && (state != S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_wm8978_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wm8978_cfg_ctrl
//  Purpose  : Directed self-checking bench for wm8978_cfg_ctrl with short
//             delays (PWR_DLY=20, GAP_DLY=4). An I2C responder answers every
//             exec 10 cycles later and can NACK a chosen data word a set
//             number of times. A second instance built with WL=24 runs
//             alongside the first configuration.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wm8978_cfg_ctrl;

  localparam int PWR = 20;
  localparam int GAP = 4;
  localparam int ACK_LAT = 10;
  // exec-to-exec spacing: ACK_LAT to done, 1 cycle to leave WACK, GAP cycles
  localparam int SPACING = ACK_LAT + 1 + GAP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        vol_req = 1'b0;
  logic [5:0]  vol_in = 6'd0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_err = 1'b0;
  logic        i2c_exec;
  logic [15:0] i2c_data;
  logic        busy, cfg_done, cfg_err;

  logic        d24_done = 1'b0;
  logic        d24_exec;
  logic [15:0] d24_data;
  logic        d24_busy, d24_cfg_done, d24_cfg_err;

  wm8978_cfg_ctrl #(.WL(6'd16), .PWR_DLY(20'd20), .GAP_DLY(16'd4),
                    .MAX_RETRY(3'd3), .VOL_INIT(6'd40)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .vol_req(vol_req),
    .vol_in(vol_in), .i2c_done(i2c_done), .i2c_ack_err(i2c_ack_err),
    .i2c_exec(i2c_exec), .i2c_data(i2c_data), .busy(busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err));

  wm8978_cfg_ctrl #(.WL(6'd24), .PWR_DLY(20'd20), .GAP_DLY(16'd4),
                    .MAX_RETRY(3'd3), .VOL_INIT(6'd40)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .cfg_start(1'b0), .vol_req(1'b0),
    .vol_in(6'd0), .i2c_done(d24_done), .i2c_ack_err(1'b0),
    .i2c_exec(d24_exec), .i2c_data(d24_data), .busy(d24_busy),
    .cfg_done(d24_cfg_done), .cfg_err(d24_cfg_err));

  always #5 clk = ~clk;

  // Posedges since the last reset release; cycle 1 is the release cycle,
  // so an exec seen after posedge k is in cycle k+1.
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // I2C responder for the main instance
  int          pend = 0;
  int          exec_cnt = 0;
  int          nack_used = 0;
  int          nack_limit = 0;
  logic [15:0] nack_data = 16'hFFFF;
  logic        stray = 1'b0;
  logic [15:0] cur = 16'h0;
  logic [15:0] log_data [0:127];
  int          log_cyc  [0:127];

  always @(negedge clk) begin
    i2c_done    = 1'b0;
    i2c_ack_err = 1'b0;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          i2c_done = 1'b1;
          if (cur == nack_data && nack_used < nack_limit) begin
            i2c_ack_err = 1'b1;
            nack_used   = nack_used + 1;
          end
        end
      end else if (stray) begin
        i2c_done = 1'b1;
      end
      if (i2c_exec && exec_cnt < 128) begin
        log_data[exec_cnt] = i2c_data;
        log_cyc[exec_cnt]  = cyc;
        exec_cnt = exec_cnt + 1;
        cur  = i2c_data;
        pend = ACK_LAT;
      end
    end
  end

  // Always-ACK responder for the WL=24 instance; keeps entry 4's data.
  int          pend24 = 0;
  int          exec24_cnt = 0;
  logic [15:0] d24_entry4 = 16'h0;
  always @(negedge clk) begin
    d24_done = 1'b0;
    if (!rst_n) begin
      pend24 = 0;
    end else begin
      if (pend24 > 0) begin
        pend24 = pend24 - 1;
        if (pend24 == 0) d24_done = 1'b1;
      end
      if (d24_exec) begin
        if (exec24_cnt == 4) d24_entry4 = d24_data;
        exec24_cnt = exec24_cnt + 1;
        pend24 = ACK_LAT;
      end
    end
  end

  int checks = 0;
  int failures = 0;
  int base = 0;
  logic [15:0] exp_tbl [0:9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_execs(input int n, input string tag);
    int t;
    t = 0;
    while ((exec_cnt - base) < n && t < 3000) begin
      step();
      t++;
    end
    chk(tag, exec_cnt - base, n);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 3000) begin
      step();
      t++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_tbl[0] = 16'h0000; exp_tbl[1] = 16'h021B; exp_tbl[2] = 16'h05B3;
    exp_tbl[3] = 16'h066F; exp_tbl[4] = 16'h0810; exp_tbl[5] = 16'h0C00;
    exp_tbl[6] = 16'h1D08; exp_tbl[7] = 16'h5833;
    exp_tbl[8] = 16'h6928;   // {7'd52, 1'b1, 2'b00, 6'd40}
    exp_tbl[9] = 16'h6B28;   // {7'd53, 1'b1, 2'b00, 6'd40}

    // ---- reset state
    step(); step();
    chk("rst_exec", i2c_exec, 1'b0);
    chk("rst_data", i2c_data, 16'h0000);
    chk("rst_busy", busy, 1'b1);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err",  cfg_err, 1'b0);

    // ---- full power-up sequence
    base  = exec_cnt;
    rst_n = 1'b1;
    wait_execs(10, "t1_exec_count");
    chk("t1_first_exec_cycle", log_cyc[base] + 1, PWR + 1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t1_data%0d", i), log_data[base+i], exp_tbl[i]);
    end
    for (int i = 1; i < 10; i++) begin
      chk($sformatf("t1_spacing%0d", i), log_cyc[base+i] - log_cyc[base+i-1], SPACING);
    end
    while (cyc < log_cyc[base+9] + ACK_LAT) step();
    chk("t1_done_before_final_ack", cfg_done, 1'b0);
    step();
    chk("t1_done_after_final_ack", cfg_done, 1'b1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_err", cfg_err, 1'b0);

    // ---- WL=24 build: R4 = {2'b00, 2'b10, 5'b10000}
    chk("t2_wl24_entry4", d24_entry4, 16'h0850);
    chk("t2_wl24_done", d24_cfg_done, 1'b1);

    // ---- cfg_start and vol_req together: full rerun, volume stays 40
    base = exec_cnt;
    cfg_start = 1'b1; vol_req = 1'b1; vol_in = 6'd5;
    step();
    cfg_start = 1'b0; vol_req = 1'b0;
    chk("t5b_busy_in_pwr", busy, 1'b1);
    chk("t5b_no_exec", i2c_exec, 1'b0);
    wait_execs(10, "t5b_exec_count");
    chk("t5b_first", log_data[base], exp_tbl[0]);
    chk("t5b_r52", log_data[base+8], exp_tbl[8]);
    chk("t5b_r53", log_data[base+9], exp_tbl[9]);
    wait_idle("t5b_idle");

    // ---- runtime volume update
    base = exec_cnt;
    vol_req = 1'b1; vol_in = 6'd10;
    step();
    vol_req = 1'b0;
    chk("t5_exec_next_cycle", i2c_exec, 1'b1);
    chk("t5_r52_data", i2c_data, 16'h690A);   // {7'd52, 1'b1, 2'b00, 6'd10}
    step(); step();
    vol_req = 1'b1; vol_in = 6'd20;           // busy: must be ignored
    step();
    vol_req = 1'b0;
    wait_execs(2, "t5_exec_count");
    chk("t5_r53_data", log_data[base+1], 16'h6B0A);
    chk("t5_spacing", log_cyc[base+1] - log_cyc[base], SPACING);
    wait_idle("t5_idle");
    chk("t5_done", cfg_done, 1'b1);
    repeat (40) step();
    chk("t5_busy_req_dropped", exec_cnt - base, 2);

    // ---- entry 3 NACKed twice, then ACKed
    nack_data  = 16'h066F;
    nack_limit = nack_used + 2;
    base = exec_cnt;
    pulse_start();
    wait_execs(12, "t3_exec_count");
    chk("t3_try1", log_data[base+3], 16'h066F);
    chk("t3_try2", log_data[base+4], 16'h066F);
    chk("t3_try3", log_data[base+5], 16'h066F);
    chk("t3_next", log_data[base+6], 16'h0810);
    chk("t3_resend_gap1", log_cyc[base+4] - log_cyc[base+3], SPACING);
    chk("t3_resend_gap2", log_cyc[base+5] - log_cyc[base+4], SPACING);
    wait_idle("t3_idle");
    chk("t3_done", cfg_done, 1'b1);

    // ---- entry 5 always NACKed: 4 attempts, then ERR
    nack_data  = 16'h0C00;
    nack_limit = nack_used + 100;
    base = exec_cnt;
    pulse_start();
    wait_idle("t4_leaves_busy");
    chk("t4_err", cfg_err, 1'b1);
    chk("t4_done", cfg_done, 1'b0);
    chk("t4_exec_count", exec_cnt - base, 9);
    for (int i = 5; i < 9; i++) begin
      chk($sformatf("t4_attempt%0d", i - 4), log_data[base+i], 16'h0C00);
    end
    repeat (50) step();
    chk("t4_no_more_exec", exec_cnt - base, 9);
    chk("t4_err_sticky", cfg_err, 1'b1);
    nack_limit = nack_used;
    base = exec_cnt;
    pulse_start();
    chk("t4_restart_busy", busy, 1'b1);
    wait_execs(10, "t4_rerun_count");
    wait_idle("t4_rerun_idle");
    chk("t4_rerun_done", cfg_done, 1'b1);

    // ---- reset during WACK of entry 6
    base = exec_cnt;
    pulse_start();
    wait_execs(7, "t6_reach_entry6");
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_exec", i2c_exec, 1'b0);
    chk("t6_rst_busy", busy, 1'b1);
    chk("t6_rst_data", i2c_data, 16'h0000);
    step(); step();
    base  = exec_cnt;
    rst_n = 1'b1;
    repeat (5) step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    chk("t6_stray_ignored", exec_cnt - base, 0);
    wait_execs(10, "t6_exec_count");
    chk("t6_first_exec_cycle", log_cyc[base] + 1, PWR + 1);
    chk("t6_first_data", log_data[base], 16'h0000);
    wait_idle("t6_idle");
    chk("t6_done", cfg_done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
